// File: rtl/mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the mem_arbiter block.
// Contents:
//   - arb_state_e : arbiter state encoding. The encoding equals the owner code,
//                   so the top can expose the state directly as `owner`.
//   - OWNER_*     : owner codes (00 idle, 01 m0, 10 m1).
//   - ADDR_W_DEF / DATA_W_DEF : default RAM geometry (64K x 8).
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  localparam logic [1:0] OWNER_IDLE = 2'b00;
  localparam logic [1:0] OWNER_M0   = 2'b01;
  localparam logic [1:0] OWNER_M1   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = OWNER_IDLE,
    ST_OWN0 = OWNER_M0,
    ST_OWN1 = OWNER_M1
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles both requester ports and the RAM-side signals of mem_arbiter.
// Modports:
//   slave  : the arbiter (takes requests, drives grants, read data, RAM inputs)
//   master : the environment (requesters m0/m1 and the RAM itself)
// Handshake: a requester raises mX_req with mX_we/addr/wdata/lock stable and
// holds them until it samples mX_gnt=1 in a cycle; the access happens in that
// cycle. For reads, mX_rvalid is high for exactly one cycle afterwards with
// mX_rdata valid; mX_rdata holds its value while mX_rvalid=0.
// ----------------------------------------------------------------------------
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  // Requester 0 (CPU)
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_lock;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  // Requester 1 (loader / debug)
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_lock;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_err;

  // RAM side
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output ram_addr, ram_din, ram_we,
    input  ram_dout
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  ram_addr, ram_din, ram_we,
    output ram_dout
  );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// ----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker.
// Ports:
//   req_i        [1:0] request vector (bit 0 = m0, bit 1 = m1)
//   last_owner_i       index of the port granted at the previous arbitration
//   grant_idx_o        index of the winner (meaningful only when any_req_o=1)
//   any_req_o          at least one request is present
// ----------------------------------------------------------------------------
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic       grant_idx_o,
  output logic       any_req_o
);

  always_comb begin
    any_req_o = |req_i;
    // On a tie the port that did not win last time goes next; otherwise the
    // single requester wins (req_i[1] selects m1, else m0).
    if (&req_i) begin
      grant_idx_o = ~last_owner_i;
    end else begin
      grant_idx_o = req_i[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares a single-port 64K x 8 RAM (async read, posedge write) between the
// CPU (m0) and the loader/debug port (m1). Round-robin fairness, optional
// locked bursts of up to MAX_BURST accesses, one RAM access per cycle.
// Ports:
//   clk    system clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    mem_arbiter_if.slave: m0/m1 request ports and the RAM inputs/output
//   owner  current owner / FSM state (00 idle, 01 m0, 10 m1)
// Build option:
//   ADDR_PROTECT_EN - when defined, m1 writes to addresses <= PROT_LIMIT are
//   granted but suppressed at the RAM, and m1_err pulses the cycle after.
//   When undefined, m1_err is constant 0 and every write reaches the RAM.
// ----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W     = ADDR_W_DEF,
  parameter int                DATA_W     = DATA_W_DEF,
  parameter int                MAX_BURST  = 4,
  parameter logic [ADDR_W-1:0] PROT_LIMIT = ADDR_W'(16'h01FF)
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_arbiter_if.slave        bus,
  output logic [1:0]          owner
);

`ifdef ADDR_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  // Wide enough to hold MAX_BURST-1, the highest value the counter reaches.
  localparam int BCW = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;        // 0 = m0 won last, 1 = m1 won last
  logic [BCW-1:0]    burst_q, burst_d;
  logic              m0_rvalid_q, m1_rvalid_q, m1_err_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

  logic pick_idx;
  logic any_req;
  logic burst_ok;
  logic stay;
  logic prot_block;
  logic m0_gnt, m1_gnt;

  rr_pick2 u_pick (
    .req_i        ({bus.m1_req, bus.m0_req}),
    .last_owner_i (last_q),
    .grant_idx_o  (pick_idx),
    .any_req_o    (any_req)
  );

  // ---------------------------------------------------------------- next state
  assign burst_ok = (int'(burst_q) < (MAX_BURST - 1));

  // A locked owner keeps the RAM without re-arbitration until the burst
  // allowance is used up; with MAX_BURST=1 burst_ok is never true.
  assign stay = burst_ok &&
                (((state_q == ST_OWN0) && bus.m0_req && bus.m0_lock) ||
                 ((state_q == ST_OWN1) && bus.m1_req && bus.m1_lock));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    if (stay) begin
      burst_d = burst_q + BCW'(1);
    end else if (any_req) begin
      state_d = pick_idx ? ST_OWN1 : ST_OWN0;
      last_d  = pick_idx;
      burst_d = '0;
    end else begin
      state_d = ST_IDLE;
      burst_d = '0;
    end
  end

  // ------------------------------------------------------------ output decode
  // Grants and RAM controls decode from the registered state and the live
  // request, so an owner that drops req gets no access that cycle and a reset
  // removes ram_we immediately (no write on the following edge).
  assign m0_gnt = (state_q == ST_OWN0) && bus.m0_req;
  assign m1_gnt = (state_q == ST_OWN1) && bus.m1_req;

  assign prot_block = PROT_EN && bus.m1_we && (bus.m1_addr <= PROT_LIMIT);

  always_comb begin
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    bus.ram_we   = 1'b0;
    case (state_q)
      ST_OWN0: begin
        bus.ram_addr = bus.m0_addr;
        bus.ram_din  = bus.m0_wdata;
        bus.ram_we   = bus.m0_req && bus.m0_we;
      end
      ST_OWN1: begin
        bus.ram_addr = bus.m1_addr;
        bus.ram_din  = bus.m1_wdata;
        bus.ram_we   = bus.m1_req && bus.m1_we && !prot_block;
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------- state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;           // m1 counted as last owner: m0 wins first tie
      burst_q     <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m1_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      burst_q     <= burst_d;
      // RAM read is asynchronous: capture dout at the end of the grant cycle.
      m0_rvalid_q <= m0_gnt && !bus.m0_we;
      m1_rvalid_q <= m1_gnt && !bus.m1_we;
      if (m0_gnt && !bus.m0_we) m0_rdata_q <= bus.ram_dout;
      if (m1_gnt && !bus.m1_we) m1_rdata_q <= bus.ram_dout;
      m1_err_q    <= m1_gnt && prot_block;
    end
  end

  assign bus.m0_gnt    = m0_gnt;
  assign bus.m1_gnt    = m1_gnt;
  assign bus.m0_rvalid = m0_rvalid_q;
  assign bus.m1_rvalid = m1_rvalid_q;
  assign bus.m0_rdata  = m0_rdata_q;
  assign bus.m1_rdata  = m1_rdata_q;
  assign bus.m1_err    = m1_err_q;
  assign owner         = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a behavioural 64K x 8 RAM (async read,
// posedge write). A per-cycle vector table covers arbitration and read
// latency; hand-written sequences cover locked bursts, reset during a write
// and the m1 address protection (expectations follow ADDR_PROTECT_EN).
// Inputs are driven 1 time unit after the rising edge, outputs sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
  import mem_arb_pkg::*;

`ifdef ADDR_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  // ------------------------------------------------------ clock / reset block
  logic       clk;
  logic       rst_n;
  logic [1:0] owner;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  mem_arbiter #(.MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .owner (owner)
  );

  // Behavioural RAM plus a back-door preload port used only while in reset.
  logic [7:0]  mem [0:65535];
  logic        bk_we;
  logic [15:0] bk_addr;
  logic [7:0]  bk_data;

  assign bus.ram_dout = mem[bus.ram_addr];

  always @(posedge clk) begin
    if (bus.ram_we)  mem[bus.ram_addr] <= bus.ram_din;
    else if (bk_we)  mem[bk_addr] <= bk_data;
  end

  // ---------------------------------------------------------------- scoreboard
  int total;
  int bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ driver tasks
  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    bk_addr = a;
    bk_data = d;
    bk_we   = 1'b1;
    @(posedge clk);
    #1 bk_we = 1'b0;
  endtask

  task automatic idle_inputs();
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_lock = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_lock = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
  endtask

  // Single m1 write; returns ram_we seen in the grant cycle and m1_err the
  // cycle after.
  task automatic m1_write(input logic [15:0] a, input logic [7:0] d, input string tag,
                          output logic we_seen, output logic err_seen);
    bit got;
    @(posedge clk);
    #1 bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = a; bus.m1_wdata = d;
    got = 0;
    we_seen = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (bus.m1_gnt) begin
        got = 1;
        we_seen = bus.ram_we;
      end
    end
    chk({tag, "_gnt_seen"}, 32'(got), 32'd1);
    @(posedge clk);
    #1 bus.m1_req = 0; bus.m1_we = 0;
    @(negedge clk);
    err_seen = bus.m1_err;
  endtask

  // ------------------------------------------------------------ vector table
  typedef struct {
    logic        r0;
    logic [15:0] a0;
    logic        r1;
    logic [15:0] a1;
    logic [1:0]  e_gnt;     // {m1_gnt, m0_gnt}
    logic [1:0]  e_owner;
    logic        e_rv0;
    logic [7:0]  e_rd0;
    logic        e_rv1;
    logic [7:0]  e_rd1;
  } vec_t;

  function automatic vec_t mk(input logic r0, input logic [15:0] a0,
                              input logic r1, input logic [15:0] a1,
                              input logic [1:0] eg, input logic [1:0] eo,
                              input logic ev0, input logic [7:0] ed0,
                              input logic ev1, input logic [7:0] ed1);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
    v.e_gnt = eg; v.e_owner = eo;
    v.e_rv0 = ev0; v.e_rd0 = ed0; v.e_rv1 = ev1; v.e_rd1 = ed1;
    return v;
  endfunction

  vec_t vt [15];

  // ------------------------------------------------------------- main test
  initial begin
    logic [1:0] exp_g [9];
    logic       g0, g1, we_seen, err_seen, got;
    int         idx;

    total = 0;
    bad   = 0;
    bk_we = 0; bk_addr = '0; bk_data = '0;
    rst_n = 0;
    idle_inputs();

    // Reads only; all reads are from the preloaded bytes below.
    vt[0]  = mk(1, 16'h0001, 1, 16'h0002, 2'b00, 2'b00, 0, 8'h00, 0, 8'h00);
    vt[1]  = mk(1, 16'h0001, 1, 16'h0002, 2'b01, 2'b01, 0, 8'h00, 0, 8'h00);
    vt[2]  = mk(1, 16'h0001, 1, 16'h0002, 2'b10, 2'b10, 1, 8'h11, 0, 8'h00);
    vt[3]  = mk(1, 16'h0001, 1, 16'h0002, 2'b01, 2'b01, 0, 8'h11, 1, 8'h22);
    vt[4]  = mk(0, 16'h0000, 1, 16'h0002, 2'b10, 2'b10, 1, 8'h11, 0, 8'h22);
    vt[5]  = mk(0, 16'h0000, 0, 16'h0000, 2'b00, 2'b10, 0, 8'h11, 1, 8'h22);
    vt[6]  = mk(0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 0, 8'h11, 0, 8'h22);
    vt[7]  = mk(1, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 0, 8'h11, 0, 8'h22);
    vt[8]  = mk(1, 16'h0000, 0, 16'h0000, 2'b01, 2'b01, 0, 8'h11, 0, 8'h22);
    vt[9]  = mk(0, 16'h0000, 0, 16'h0000, 2'b00, 2'b01, 1, 8'hBB, 0, 8'h22);
    vt[10] = mk(0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 0, 8'hBB, 0, 8'h22);
    vt[11] = mk(0, 16'h0000, 1, 16'h0003, 2'b00, 2'b00, 0, 8'hBB, 0, 8'h22);
    vt[12] = mk(0, 16'h0000, 1, 16'h0003, 2'b10, 2'b10, 0, 8'hBB, 0, 8'h22);
    vt[13] = mk(0, 16'h0000, 0, 16'h0000, 2'b00, 2'b10, 0, 8'hBB, 1, 8'h33);
    vt[14] = mk(0, 16'h0000, 0, 16'h0000, 2'b00, 2'b00, 0, 8'hBB, 0, 8'h33);

    // Preload RAM while held in reset.
    preload(16'h0000, 8'hBB);
    preload(16'h0001, 8'h11);
    preload(16'h0002, 8'h22);
    preload(16'h0003, 8'h33);
    preload(16'h0006, 8'h66);
    preload(16'h0010, 8'h77);
    preload(16'h0200, 8'h00);
    preload(16'hFFFE, 8'h3C);

    // Reset state.
    @(negedge clk);
    chk("rst_owner",  32'(owner), 32'(OWNER_IDLE));
    chk("rst_gnt",    32'({bus.m1_gnt, bus.m0_gnt}), 32'd0);
    chk("rst_rvalid", 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'd0);
    chk("rst_rdata0", 32'(bus.m0_rdata), 32'd0);
    chk("rst_rdata1", 32'(bus.m1_rdata), 32'd0);
    chk("rst_err",    32'(bus.m1_err), 32'd0);
    chk("rst_ram",    32'({bus.ram_we, bus.ram_addr, bus.ram_din}), 32'd0);
    rst_n = 1;

    // Table: tie from reset, alternation, single read latency, drop to idle.
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      bus.m0_req = vt[i].r0; bus.m0_addr = vt[i].a0; bus.m0_we = 0; bus.m0_lock = 0;
      bus.m1_req = vt[i].r1; bus.m1_addr = vt[i].a1; bus.m1_we = 0; bus.m1_lock = 0;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i),    32'({bus.m1_gnt, bus.m0_gnt}), 32'(vt[i].e_gnt));
      chk($sformatf("v%0d_owner", i),  32'(owner), 32'(vt[i].e_owner));
      chk($sformatf("v%0d_rvalid0", i), 32'(bus.m0_rvalid), 32'(vt[i].e_rv0));
      chk($sformatf("v%0d_rdata0", i),  32'(bus.m0_rdata), 32'(vt[i].e_rd0));
      chk($sformatf("v%0d_rvalid1", i), 32'(bus.m1_rvalid), 32'(vt[i].e_rv1));
      chk($sformatf("v%0d_rdata1", i),  32'(bus.m1_rdata), 32'(vt[i].e_rd1));
      chk($sformatf("v%0d_ram_we", i),  32'(bus.ram_we), 32'd0);
    end

    // Locked m1 burst of 6 writes against a competing m0 read.
    exp_g[0] = 2'b00; exp_g[1] = 2'b10; exp_g[2] = 2'b10; exp_g[3] = 2'b10;
    exp_g[4] = 2'b10; exp_g[5] = 2'b01; exp_g[6] = 2'b10; exp_g[7] = 2'b10;
    exp_g[8] = 2'b00;
    idx = 0;
    @(posedge clk);
    #1 bus.m1_req = 1; bus.m1_we = 1; bus.m1_lock = 1; bus.m1_addr = 16'h0200; bus.m1_wdata = 8'hA0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("burst_gnt_c%0d", c), 32'({bus.m1_gnt, bus.m0_gnt}), 32'(exp_g[c]));
      if (c == 6) begin
        chk("burst_m0_rvalid", 32'(bus.m0_rvalid), 32'd1);
        chk("burst_m0_rdata",  32'(bus.m0_rdata), 32'h77);
      end
      g0 = bus.m0_gnt;
      g1 = bus.m1_gnt;
      @(posedge clk);
      #1;
      if (g1) begin
        idx++;
        if (idx == 6) begin
          bus.m1_req = 0; bus.m1_we = 0; bus.m1_lock = 0;
        end else begin
          bus.m1_addr  = 16'h0200 + 16'(idx);
          bus.m1_wdata = 8'hA0 + 8'(idx);
        end
      end
      if (c == 0) begin
        bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 16'h0010;
      end
      if (g0) bus.m0_req = 0;
    end
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("burst_ram_%0d", i), 32'(mem[16'h0200 + 16'(i)]), 32'(8'hA0 + 8'(i)));
    end

    // Reset asserted inside an m0 write grant cycle: the write must not land.
    @(posedge clk);
    #1 bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 16'hFFFE; bus.m0_wdata = 8'h5A;
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(negedge clk);
      if (bus.m0_gnt) got = 1;
    end
    chk("rstw_gnt_seen", 32'(got), 32'd1);
    chk("rstw_we_before", 32'(bus.ram_we), 32'd1);
    #2 rst_n = 0;
    #1;
    chk("rstw_we_async",  32'(bus.ram_we), 32'd0);
    chk("rstw_gnt_async", 32'({bus.m1_gnt, bus.m0_gnt}), 32'd0);
    chk("rstw_owner",     32'(owner), 32'(OWNER_IDLE));
    chk("rstw_ram_bus",   32'({bus.ram_addr, bus.ram_din}), 32'd0);
    @(posedge clk);
    #1;
    chk("rstw_ram_kept",  32'(mem[16'hFFFE]), 32'h3C);
    bus.m0_req = 0; bus.m0_we = 0;
    @(negedge clk);
    rst_n = 1;

    // m1 write into the protected range, then just above it.
    m1_write(16'h0006, 8'hFF, "prot", we_seen, err_seen);
    chk("prot_ram_we", 32'(we_seen), 32'(!PROT));
    chk("prot_err",    32'(err_seen), 32'(PROT));
    chk("prot_ram",    32'(mem[16'h0006]), PROT ? 32'h66 : 32'hFF);
    m1_write(16'h0200, 8'h99, "open", we_seen, err_seen);
    chk("open_ram_we", 32'(we_seen), 32'd1);
    chk("open_err",    32'(err_seen), 32'd0);
    chk("open_ram",    32'(mem[16'h0200]), 32'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog: the directed sequences need only a few hundred cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port 64K x 8 program/data RAM between the CPU (port m0) and the program loader/debug port (port m1).
- The RAM has asynchronous read and a posedge write on `we`. The arbiter owns the RAM address/data/write-enable inputs and returns registered read data to whichever requester was granted.
- Round-robin fairness, optional burst locking, one RAM access per cycle.

Parameters:
- ADDR_W, 16, RAM address width.
- DATA_W, 8, RAM data width.
- MAX_BURST, 4, maximum consecutive locked accesses by one owner before arbitration is forced (>=1).
- PROT_LIMIT, 16'h01FF, highest address protected from m1 writes (used only with ADDR_PROTECT_EN).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- m0_req, m1_req  in  1  access request; must hold until the matching gnt.
- m0_we, m1_we  in  1  1 = write, 0 = read; held with req.
- m0_addr, m1_addr  in  ADDR_W  access address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_lock, m1_lock  in  1  request to keep ownership for the next access (burst).
- m0_gnt, m1_gnt  out  1  access performed this cycle.
- m0_rvalid, m1_rvalid  out  1  read data valid, one cycle after a read gnt.
- m0_rdata, m1_rdata  out  DATA_W  registered read data.
- m1_err  out  1  protection violation pulse.
- ram_addr  out  ADDR_W  to RAM addr.
- ram_din  out  DATA_W  to RAM din.
- ram_we  out  1  to RAM we.
- ram_dout  in  DATA_W  from RAM dout.
- owner  out  2  00 idle, 01 m0, 10 m1.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_owner=m1 (so m0 wins the first tie), burst_cnt=0.
  - All gnt/rvalid/err outputs 0, rdata 0, ram_we 0, ram_addr/ram_din 0, owner=00.
  - ram_we is decoded from state, so it drops asynchronously. A write whose edge has not yet occurred when reset asserts is not performed.
- States:
  - IDLE: RAM inputs driven 0, no gnt.
  - OWN0: RAM driven from m0 fields. m0_gnt = m0_req. ram_we = m0_req & m0_we.
  - OWN1: same, driven from m1 fields.
- Transitions at each rising edge, evaluated with current inputs:
  - In OWNx, if req_x & lock_x & (burst_cnt < MAX_BURST-1): stay in OWNx, burst_cnt++.
  - Otherwise, arbitrate:
    - Both requesting: grant the one that is not last_owner.
    - One requesting: grant that one.
    - None requesting: go to IDLE.
  - On arbitration, burst_cnt=0 and last_owner is updated to the granted port.
  - A non-locked owner that keeps requesting while the other is idle is re-granted with no bubble.
- Latency:
  - From IDLE: req seen at edge N → gnt during cycle N+1.
  - Back-to-back accesses: one per cycle with no idle cycle.
- Reads: ram_dout is captured at the end of the gnt cycle; rdata and rvalid appear the following cycle for one cycle. rdata holds its value when rvalid=0.
- Writes: committed by the RAM on the edge ending the gnt cycle. The requester drops or changes req after seeing gnt.
- Owner drops req while in OWNx: no gnt, ram_we=0, arbitration happens at the next edge.
- Lock is ignored once MAX_BURST accesses are done. With MAX_BURST=1, lock has no effect.
- Simultaneous reads by one owner in consecutive cycles: rvalid stays high for consecutive cycles.

Optional Feature:
- ADDR_PROTECT_EN defined:
  - An m1 write with m1_addr <= PROT_LIMIT still receives m1_gnt, but ram_we is held 0.
  - m1_err pulses high for one cycle in the following cycle.
  - m0 is never blocked.
- ADDR_PROTECT_EN not defined: m1_err is tied 0 and all writes pass.

Decomposition:
- Package mem_arb_pkg:
  - state encoding IDLE/OWN0/OWN1;
  - owner codes 2'b00/01/10;
  - ADDR_W/DATA_W defaults.
- Sub-module rr_pick2: combinational 2-way round-robin picker. Inputs req[1:0] and last_owner; outputs grant_idx and any_req. Instantiated once.

Test Plan:
- m0 reads 16'h0000 with RAM byte 8'hBB and m1 idle → m0_gnt in cycle 1 after req, m0_rvalid=1 and m0_rdata=8'hBB in cycle 2, owner=01.
- m0 and m1 request in the same cycle from reset → m0 granted first, m1 granted the next cycle. Both continue requesting → gnt alternates m0,m1,m0,...
- m1 locked burst of 6 writes to 16'h0200..0205 while m0 requests, MAX_BURST=4 → m1 gets 4 consecutive gnts, then m0 gets 1, then m1 finishes 2. RAM contents are correct afterwards.
- m0 write of 8'h5A to 16'hFFFE with rst_n asserted mid-cycle before the edge → all outputs 0 immediately, RAM[16'hFFFE] unchanged, state IDLE.
- With ADDR_PROTECT_EN: m1 writes 8'hFF to 16'h0006 → m1_gnt=1, ram_we=0, m1_err=1 the next cycle, RAM unchanged. An m1 write to 16'h0200 succeeds with m1_err=0.
- Owner drops req without lock while the other port is idle → IDLE on the next edge, owner=00. A new req gets gnt one cycle later.
